// File: rtl/mult_8x8_seq_ctrl_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
// Optional build macro APPROX_LSB_EN: skip the LL partial product (step 0),
// giving a 3-step schedule and a product that is low by A[3:0]*B[3:0].
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STEP_W = 2;

`ifdef APPROX_LSB_EN
    localparam logic [STEP_W-1:0] STEP_FIRST = 2'd1;
`else
    localparam logic [STEP_W-1:0] STEP_FIRST = 2'd0;
`endif
    localparam logic [STEP_W-1:0] STEP_LAST  = 2'd3;

    localparam logic [3:0] SHIFT_LL = 4'd0;
    localparam logic [3:0] SHIFT_LH = 4'd4;
    localparam logic [3:0] SHIFT_HL = 4'd4;
    localparam logic [3:0] SHIFT_HH = 4'd8;

    // Left-shift applied to the partial product selected by a given step.
    function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
        logic [3:0] sh;
        case (step)
            2'd0:    sh = SHIFT_LL;
            2'd1:    sh = SHIFT_LH;
            2'd2:    sh = SHIFT_HL;
            default: sh = SHIFT_HH;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mult_8x8_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential 8x8 multiplier.
// Optional build macro APPROX_LSB_EN does not change this interface.
interface mult_8x8_seq_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] R;
    logic        busy;

    modport master (
        output in_valid,
        output A,
        output B,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  R,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  out_ready,
        output in_ready,
        output out_valid,
        output R,
        output busy
    );

endinterface

// File: rtl/mult_8x8_seq_ctrl_mult.sv
// Combinational exact 4x4 -> 8 unsigned multiplier, shared across all
// nibble partial products. Unaffected by APPROX_LSB_EN.
module mult_4x4_exact (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);

    assign o_p = {4'b0000, i_a} * {4'b0000, i_b};

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: one 4x4 multiplier time-shared over
// the LL/LH/HL/HH nibble products, accumulated into a 16-bit result.
// Optional build macro APPROX_LSB_EN (see mult_seq_pkg) starts at step 1.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// CALC  | one partial product accumulated per cycle, step STEP_FIRST..3
// DONE  | R valid, held until out_ready
module mult_8x8_seq_ctrl
    import mult_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    mult_8x8_seq_ctrl_if.slave   bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [STEP_W-1:0]  r_step;
    logic [STEP_W-1:0]  w_step_nxt;
    logic [15:0]        r_acc;
    logic [15:0]        w_acc_nxt;
    logic [7:0]         r_op_a;
    logic [7:0]         r_op_b;
    logic [7:0]         w_op_a_nxt;
    logic [7:0]         w_op_b_nxt;

    logic [3:0]         w_sub_a;
    logic [3:0]         w_sub_b;
    logic [7:0]         w_pp;
    logic [15:0]        w_pp_shifted;

    // Operand select: step bit 1 picks the A nibble, step bit 0 the B nibble.
    always_comb begin
        w_sub_a      = r_step[1] ? r_op_a[7:4] : r_op_a[3:0];
        w_sub_b      = r_step[0] ? r_op_b[7:4] : r_op_b[3:0];
        w_pp_shifted = 16'(w_pp) << step_shift(r_step);
    end

    mult_4x4_exact u_mult (
        .i_a (w_sub_a),
        .i_b (w_sub_b),
        .o_p (w_pp)
    );

    // Next-state, step, operand capture and accumulation.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_acc_nxt   = r_acc;
        w_op_a_nxt  = r_op_a;
        w_op_b_nxt  = r_op_b;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_op_a_nxt  = bus.A;
                    w_op_b_nxt  = bus.B;
                    w_acc_nxt   = 16'd0;
                    w_step_nxt  = STEP_FIRST;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                w_acc_nxt  = r_acc + w_pp_shifted;
                w_step_nxt = r_step + STEP_W'(1);
                if (r_step == STEP_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_acc   <= 16'd0;
            r_op_a  <= 8'd0;
            r_op_b  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_acc   <= w_acc_nxt;
            r_op_a  <= w_op_a_nxt;
            r_op_b  <= w_op_b_nxt;
        end
    end

    // Handshake outputs decode registered state only, so no input feeds them.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.R         = r_acc;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Self-checking bench for mult_8x8_seq_ctrl; expected products come from a
// scoreboard queue filled at operand acceptance. Honours APPROX_LSB_EN.
module tb_mult_8x8_seq_ctrl;

`ifdef APPROX_LSB_EN
    localparam int LAT    = 3;
    localparam int PERIOD = 5;
`else
    localparam int LAT    = 4;
    localparam int PERIOD = 6;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic [15:0] sb_q[$];

    mult_8x8_seq_ctrl_if bus();

    mult_8x8_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
`ifdef APPROX_LSB_EN
        p = p - 16'(a[3:0]) * 16'(b[3:0]);
`endif
        return p;
    endfunction

    task automatic drive_accept(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        sb_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 20 && !ok) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.out_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = 8'd0;
        bus.B         = 8'd0;
        #1 rst_n = 1'b0;
        #3;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.R !== 16'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b R=%h busy=%b, need 1 0 0000 0",
                     bus.in_ready, bus.out_valid, bus.R, bus.busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b, need 1 0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_basic();
        int n; bit ok; logic [15:0] exp;
        bus.out_ready = 1'b1;
        drive_accept(8'hFF, 8'hFF);
        wait_out(n, ok);
        checks++;
        if (!ok || n !== LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles (seen=%0b), need %0d", n, ok, LAT);
        end
        exp = sb_q.pop_front();
        checks++;
        if (bus.R !== exp) begin
            errors++;
            $display("FAIL basic_result: R=%h, need %h", bus.R, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_return: out_valid=%b in_ready=%b, need 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        int n; bit ok; logic [15:0] exp; int bad;
        bus.out_ready = 1'b0;
        drive_accept(8'd13, 8'd200);
        wait_out(n, ok);
        checks++;
        if (!ok || n !== LAT) begin
            errors++;
            $display("FAIL bp_latency: got %0d cycles (seen=%0b), need %0d", n, ok, LAT);
        end
        exp = sb_q.pop_front();
        checks++;
        if (bus.R !== exp) begin
            errors++;
            $display("FAIL bp_result: R=%0d, need %0d", bus.R, exp);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.R !== exp || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d of 10 stalled cycles lost out_valid/R/in_ready/busy, need 0", bad);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, need 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_ignored_input();
        int n; bit ok; logic [15:0] exp; int extra;
        bus.out_ready = 1'b1;
        drive_accept(8'h12, 8'h34);
        @(negedge clk);
        bus.A        = 8'h01;
        bus.B        = 8'h01;
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_out(n, ok);
        checks++;
        if (!ok || n !== LAT - 2) begin
            errors++;
            $display("FAIL ign_latency: got %0d remaining cycles (seen=%0b), need %0d", n, ok, LAT - 2);
        end
        exp = sb_q.pop_front();
        checks++;
        if (bus.R !== exp) begin
            errors++;
            $display("FAIL ign_result: R=%h, need %h", bus.R, exp);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ign_no_second_op: %0d cycles busy/out_valid after return, need 0", extra);
        end
    endtask

    task automatic test_mid_reset();
        int n; bit ok; logic [15:0] exp;
        bus.out_ready = 1'b1;
        drive_accept(8'hFF, 8'hFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.R !== 16'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: in_ready=%b out_valid=%b R=%h busy=%b, need 1 0 0000 0",
                     bus.in_ready, bus.out_valid, bus.R, bus.busy);
        end
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive_accept(8'd0, 8'd77);
        wait_out(n, ok);
        checks++;
        if (!ok || n !== LAT) begin
            errors++;
            $display("FAIL midreset_latency: got %0d cycles (seen=%0b), need %0d", n, ok, LAT);
        end
        exp = sb_q.pop_front();
        checks++;
        if (bus.R !== exp) begin
            errors++;
            $display("FAIL midreset_result: R=%h, need %h", bus.R, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        int results  = 0;
        int last_acc = 0;
        int guard    = 0;
        logic [7:0]  a, b;
        logic [15:0] exp;
        bus.out_ready = 1'b1;
        sb_q.delete();
        while (results < 100 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (bus.out_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: R=%h with empty scoreboard", bus.R);
                end else begin
                    exp = sb_q.pop_front();
                    if (bus.R !== exp) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: R=%h, need %h", results, bus.R, exp);
                    end
                end
                results++;
            end
            if (bus.in_ready && accepted < 100) begin
                a = 8'($urandom);
                b = 8'($urandom);
                bus.A        = a;
                bus.B        = b;
                bus.in_valid = 1'b1;
                sb_q.push_back(model(a, b));
                if (accepted > 0) begin
                    checks++;
                    if (cyc - last_acc != PERIOD) begin
                        errors++;
                        $display("FAIL b2b_period[%0d]: %0d cycles between accepts, need %0d",
                                 accepted, cyc - last_acc, PERIOD);
                    end
                end
                last_acc = cyc;
                accepted++;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (results != 100) begin
            errors++;
            $display("FAIL b2b_count: %0d results within budget, need 100", results);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_input();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
